// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and constants for the register-file dump reader.
//   NUM_REGS / ADDR_W / DATA_W : register file geometry (32 x 32-bit, 5-bit index)
//   ST_*                       : dump FSM state encodings
//   fifo_entry_t               : one buffered output word {data, index, last, is_csum}
package rf_dump_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int DATA_W   = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] index;
        logic              last;
        logic              is_csum;
    } fifo_entry_t;

endpackage

// File: rtl/rf_dump_reader_if.sv
// rf_dump_reader_if: valid/ready output stream of the dump reader.
//   dout_valid   : word available (master -> slave)
//   dout_ready   : sink accepts word (slave -> master)
//   dout_data    : register value
//   dout_index   : register number of dout_data
//   dout_last    : final word of the dump
//   dout_is_csum : word is the checksum word
interface rf_dump_reader_if;
    import rf_dump_pkg::*;

    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic [ADDR_W-1:0] dout_index;
    logic              dout_last;
    logic              dout_is_csum;

    modport master (
        output dout_valid, dout_data, dout_index, dout_last, dout_is_csum,
        input  dout_ready
    );

    modport slave (
        input  dout_valid, dout_data, dout_index, dout_last, dout_is_csum,
        output dout_ready
    );

endinterface

// File: rtl/rf_dump_fifo.sv
// rf_dump_fifo: synchronous FIFO with a 2-wide push port and a 1-wide pop port.
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : empty the FIFO next cycle
//   push_cnt              : number of entries pushed this cycle (0, 1 or 2)
//   push_data0/push_data1 : entries to push, data0 goes in first
//   pop                   : remove head entry (ignored when empty)
//   head, empty, free     : head entry, empty flag, number of free slots
// DEPTH must be a power of two (pointers wrap by truncation).
module rf_dump_fifo
    import rf_dump_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [1:0]             push_cnt,
    input  fifo_entry_t            push_data0,
    input  fifo_entry_t            push_data1,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr1;
    logic [PTR_W:0]   count_reg;
    logic             do_pop;

    assign wr_ptr1 = wr_ptr_reg + PTR_W'(1);
    assign do_pop  = pop && !empty;
    assign empty   = (count_reg == '0);
    assign free    = (PTR_W+1)'(DEPTH) - count_reg;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr_reg] <= push_data0;
        end
        if (push_cnt == 2'd2) begin
            mem[wr_ptr1] <= push_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_cnt);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(do_pop);
            count_reg  <= count_reg + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks a register range through both RF read ports (two
// registers per cycle), buffers the words and streams them out.
//   clk, reset           : clock, synchronous active-high reset
//   start, abort         : begin dump (IDLE only) / cancel dump and flush
//   first_reg, last_reg  : inclusive register range, sampled with start
//   rd_addr1/2, rd_data1/2 : RF read ports (combinational read data)
//   dout                 : output stream (rf_dump_reader_if.master)
//   busy, done, err      : dump in progress / completion pulse / bad-range pulse
// Optional feature macro RF_DUMP_CHECKSUM_EN: appends an XOR checksum word
// (dout_is_csum=1, dout_index=0, dout_last=1) after the last register word.
module rf_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    rf_dump_reader_if.master  dout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
    // One extra bit so that a range ending at the top register never wraps.
    localparam int PW     = ADDR_W + 1;

`ifdef RF_DUMP_CHECKSUM_EN
    localparam bit LAST_ON_WORD = 1'b0;
`else
    localparam bit LAST_ON_WORD = 1'b1;
`endif

    logic [1:0]        state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next, end_reg, end_next, ptr_plus1;
    logic [ADDR_W-1:0] addr1_reg, addr2_reg;
    logic              err_reg, err_next;
    logic              covers_end;

    logic [1:0]        push_cnt;
    fifo_entry_t       push0, push1, head;
    logic              fifo_empty;
    logic [FREE_W-1:0] free;

`ifdef RF_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_reg, csum_next;
    logic              csum_phase_reg, csum_phase_next;
`endif

    assign ptr_plus1 = ptr_reg + PW'(1);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        end_next   = end_reg;
        err_next   = 1'b0;
        push_cnt   = 2'd0;
        push0      = '0;
        push1      = '0;
        covers_end = 1'b0;
        rd_addr1   = '0;
        rd_addr2   = '0;
`ifdef RF_DUMP_CHECKSUM_EN
        csum_next       = csum_reg;
        csum_phase_next = csum_phase_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (first_reg <= last_reg) begin
                        state_next = ST_READ;
                        ptr_next   = {1'b0, first_reg};
                        end_next   = {1'b0, last_reg};
`ifdef RF_DUMP_CHECKSUM_EN
                        csum_next       = '0;
                        csum_phase_next = 1'b0;
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // Addresses hold their previous value on a stall cycle.
                rd_addr1 = addr1_reg;
                rd_addr2 = addr2_reg;
`ifdef RF_DUMP_CHECKSUM_EN
                if (csum_phase_reg) begin
                    if (free != '0) begin
                        push_cnt        = 2'd1;
                        push0           = '{data: csum_reg, index: '0, last: 1'b1, is_csum: 1'b1};
                        csum_phase_next = 1'b0;
                        state_next      = ST_DRAIN;
                    end
                end else
`endif
                if (free >= FREE_W'(2) && end_reg > ptr_reg) begin
                    rd_addr1   = ptr_reg[ADDR_W-1:0];
                    rd_addr2   = ptr_plus1[ADDR_W-1:0];
                    push_cnt   = 2'd2;
                    push0      = '{data: rd_data1, index: ptr_reg[ADDR_W-1:0],
                                   last: 1'b0, is_csum: 1'b0};
                    push1      = '{data: rd_data2, index: ptr_plus1[ADDR_W-1:0],
                                   last: LAST_ON_WORD && (ptr_plus1 == end_reg), is_csum: 1'b0};
                    covers_end = (ptr_plus1 == end_reg);
                    ptr_next   = ptr_reg + PW'(2);
`ifdef RF_DUMP_CHECKSUM_EN
                    csum_next  = csum_reg ^ rd_data1 ^ rd_data2;
`endif
                end else if (ptr_reg == end_reg && free != '0) begin
                    rd_addr1   = ptr_reg[ADDR_W-1:0];
                    rd_addr2   = ptr_plus1[ADDR_W-1:0];
                    push_cnt   = 2'd1;
                    push0      = '{data: rd_data1, index: ptr_reg[ADDR_W-1:0],
                                   last: LAST_ON_WORD, is_csum: 1'b0};
                    covers_end = 1'b1;
                    ptr_next   = ptr_plus1;
`ifdef RF_DUMP_CHECKSUM_EN
                    csum_next  = csum_reg ^ rd_data1;
`endif
                end
                if (covers_end) begin
`ifdef RF_DUMP_CHECKSUM_EN
                    csum_phase_next = 1'b1;
`else
                    state_next = ST_DRAIN;
`endif
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // Abort overrides any progress made this cycle; the FIFO is flushed.
        if (abort && state_reg != ST_IDLE) begin
            state_next = ST_IDLE;
            push_cnt   = 2'd0;
`ifdef RF_DUMP_CHECKSUM_EN
            csum_phase_next = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            end_reg   <= '0;
            addr1_reg <= '0;
            addr2_reg <= '0;
            err_reg   <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
            csum_reg       <= '0;
            csum_phase_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            end_reg   <= end_next;
            addr1_reg <= rd_addr1;
            addr2_reg <= rd_addr2;
            err_reg   <= err_next;
`ifdef RF_DUMP_CHECKSUM_EN
            csum_reg       <= csum_next;
            csum_phase_reg <= csum_phase_next;
`endif
        end
    end

    rf_dump_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push_cnt  (push_cnt),
        .push_data0(push0),
        .push_data1(push1),
        .pop       (dout.dout_valid && dout.dout_ready),
        .head      (head),
        .empty     (fifo_empty),
        .free      (free)
    );

    // Stream fields are forced to zero while empty so stale RAM never leaks out.
    assign dout.dout_valid = !fifo_empty;
    assign dout.dout_data  = fifo_empty ? '0 : head.data;
    assign dout.dout_index = fifo_empty ? '0 : head.index;
    assign dout.dout_last  = fifo_empty ? 1'b0 : head.last;
`ifdef RF_DUMP_CHECKSUM_EN
    assign dout.dout_is_csum = fifo_empty ? 1'b0 : head.is_csum;
`else
    logic csum_flag_unused;
    assign csum_flag_unused  = head.is_csum;
    assign dout.dout_is_csum = 1'b0;
`endif

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);
    assign err  = err_reg;

endmodule

// File: tb/tb_rf_dump_reader.sv
module tb_rf_dump_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  index;
        logic        last;
        logic        csum;
    } exp_t;

`ifdef RF_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [4:0]  first_reg, last_reg, rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        busy, done, err;
    logic [31:0] rf [32];

    rf_dump_reader_if dout_if ();

    always #5 clk = ~clk;

    assign rd_data1 = rf[rd_addr1];
    assign rd_data2 = rf[rd_addr2];

    rf_dump_reader #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .first_reg(first_reg),
        .last_reg (last_reg),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .dout     (dout_if.master),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int          total = 0;
    int          bad = 0;
    int          word_cnt = 0;
    int          done_cnt = 0;
    int          addr_hits = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    logic [4:0]  watch_addr = 5'd5;
    logic [3:0]  pat = 4'b1001;
    logic        hold_valid = 1'b0;
    logic [39:0] held, cur;
    exp_t        sb[$];
    exp_t        exp_w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_range(input int f, input int l);
        logic [31:0] x;
        exp_t        e;
        x = '0;
        for (int i = f; i <= l; i++) begin
            e.data  = rf[i];
            e.index = 5'(i);
            e.last  = !CSUM && (i == l);
            e.csum  = 1'b0;
            sb.push_back(e);
            x = x ^ rf[i];
        end
        if (CSUM) begin
            e = '{data: x, index: 5'd0, last: 1'b1, csum: 1'b1};
            sb.push_back(e);
        end
    endtask

    // One clock: sample outputs at negedge, advance past posedge, set next ready.
    task automatic step();
        @(negedge clk);
        cur = {dout_if.dout_valid, dout_if.dout_data, dout_if.dout_index,
               dout_if.dout_last, dout_if.dout_is_csum};
        if (hold_valid) check("stall_hold", 64'(cur), 64'(held));
        if (dout_if.dout_valid && dout_if.dout_ready) begin
            if (sb.size() == 0) begin
                check("extra_word", 64'(dout_if.dout_index), 64'(6'h3f));
            end else begin
                exp_w = sb.pop_front();
                check("data",  64'(dout_if.dout_data),    64'(exp_w.data));
                check("index", 64'(dout_if.dout_index),   64'(exp_w.index));
                check("last",  64'(dout_if.dout_last),    64'(exp_w.last));
                check("csum",  64'(dout_if.dout_is_csum), 64'(exp_w.csum));
            end
            $display("word idx=%0d data=%08h last=%0b csum=%0b", dout_if.dout_index,
                     dout_if.dout_data, dout_if.dout_last, dout_if.dout_is_csum);
            word_cnt++;
        end
        hold_valid = dout_if.dout_valid && !dout_if.dout_ready && !reset && !abort;
        held = cur;
        if (done) done_cnt++;
        if (rd_addr1 == watch_addr) addr_hits++;
        @(posedge clk);
        #1;
        cyc++;
        dout_if.dout_ready = (ready_mode == 0) ? 1'b1 :
                             (ready_mode == 1) ? pat[cyc % 4] : 1'b0;
    endtask

    task automatic start_dump(input int f, input int l);
        first_reg = 5'(f);
        last_reg  = 5'(l);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        for (int k = 0; k < 3; k++) step();
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'(1));
        check({tag, "_busy_low"},  64'(busy), 64'(0));
        check({tag, "_sb_empty"},  64'(sb.size()), 64'(0));
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_reg = '0; last_reg = '0;
        dout_if.dout_ready = 1'b1;
        repeat (3) step();
        check("rst_valid", 64'(dout_if.dout_valid), 64'(0));
        check("rst_data",  64'(dout_if.dout_data),  64'(0));
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_done",  64'(done), 64'(0));
        check("rst_err",   64'(err),  64'(0));
        check("rst_addr",  64'({rd_addr1, rd_addr2}), 64'(0));
        reset = 1'b0;
        step();

        // Full range, sink always ready.
        base = word_cnt;
        push_range(0, 31);
        start_dump(0, 31);
        check("full_busy", 64'(busy), 64'(1));
        wait_done("full", 300);
        check("full_count", 64'(word_cnt - base), 64'(32 + int'(CSUM)));

        // Single register; rd_addr1 shows it once (held one more cycle
        // while the checksum word is pushed).
        addr_hits = 0;
        push_range(5, 5);
        start_dump(5, 5);
        wait_done("single", 50);
        check("single_addr_cycles", 64'(addr_hits), 64'(1 + int'(CSUM)));
        watch_addr = 5'd31;

        // Back-pressured range with distinct data; a start while busy is ignored.
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
        ready_mode = 1;
        base = word_cnt;
        push_range(3, 8);
        start_dump(3, 8);
        step(); step();
        start_dump(0, 1);
        wait_done("bp", 200);
        check("bp_count", 64'(word_cnt - base), 64'(6 + int'(CSUM)));
        ready_mode = 0;

        // Abort after 10 accepted words.
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        base = word_cnt;
        push_range(0, 31);
        start_dump(0, 31);
        n = 0;
        while (word_cnt - base < 10 && n < 200) begin
            step();
            n++;
        end
        check("abort_words", 64'(word_cnt - base), 64'(10));
        ready_mode = 2;
        dout_if.dout_ready = 1'b0;
        abort = 1'b1;
        base = done_cnt;
        step();
        abort = 1'b0;
        check("abort_busy",  64'(busy), 64'(0));
        check("abort_valid", 64'(dout_if.dout_valid), 64'(0));
        repeat (4) step();
        check("abort_no_done", 64'(done_cnt - base), 64'(0));
        sb.delete();
        ready_mode = 0;
        push_range(0, 1);
        start_dump(0, 1);
        wait_done("after_abort", 50);

        // Illegal range.
        base = word_cnt;
        start_dump(9, 4);
        check("err_pulse", 64'(err),  64'(1));
        check("err_busy",  64'(busy), 64'(0));
        step();
        check("err_clear", 64'(err), 64'(0));
        repeat (3) step();
        check("err_no_words", 64'(word_cnt - base), 64'(0));

        // Reset in the middle of a dump.
        ready_mode = 2;
        base = done_cnt;
        push_range(0, 31);
        start_dump(0, 31);
        repeat (5) step();
        check("pre_rst_valid", 64'(dout_if.dout_valid), 64'(1));
        reset = 1'b1;
        step();
        check("mid_rst_out", 64'({busy, done, err, rd_addr1, rd_addr2, dout_if.dout_valid,
              dout_if.dout_data, dout_if.dout_index, dout_if.dout_last, dout_if.dout_is_csum}), 64'(0));
        reset = 1'b0;
        sb.delete();
        ready_mode = 0;
        repeat (3) step();
        check("mid_rst_no_done", 64'(done_cnt - base), 64'(0));

        // Short range 1..4 (with the checksum build this ends in checksum 4).
        push_range(1, 4);
        start_dump(1, 4);
        wait_done("short", 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
